sliding_window_stream: RTL and testbench
========================================

Name: sliding_window_stream

Overview:
- Parametrised row-window buffer for the conv front end. Accepts one row of WIN_COLS signed pixels per handshake and keeps the last WIN_ROWS rows as a full window.
- Presents the window with a valid/ready handshake. Supports programmable vertical stride, downstream backpressure and a synchronous frame clear.
- Sits between the activation-fetch unit and the systolic-array input skew logic.

Parameters:
- DATA_W, 8: bits per pixel (signed).
- WIN_COLS, 4: pixels per row.
- WIN_ROWS, 4: rows held in the window.
- STRIDE_W, $clog2(WIN_ROWS+1): width of the stride input.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- clear  in  1  synchronous frame restart.
- stride  in  STRIDE_W  rows accepted between emitted windows (1..WIN_ROWS).
- in_valid  in  1  in_row valid.
- in_ready  out  1  block can accept a row.
- in_row  in  WIN_COLS*DATA_W  pixel c = in_row[c*DATA_W +: DATA_W].
- win_valid  out  1  win_data holds a complete window.
- win_ready  in  1  consumer takes the window.
- win_data  out  WIN_ROWS*WIN_COLS*DATA_W  row r, pixel c at [(r*WIN_COLS+c)*DATA_W +: DATA_W]; r=0 is the newest row.
- row_valid  out  WIN_ROWS  bit r is set when buffer row r holds data since the last clear.

Behaviour:
- Reset (reset=1): all row buffers 0, fill_cnt=0, since_cnt=0, win_valid=0, row_valid=0. Reset has priority over everything.
- clear=1 (not reset): same state effect as reset, including buffers zeroed. Any in_row offered that cycle is dropped. clear has priority over accept and win handshake.
- in_ready = !win_valid || win_ready. This is a combinational path from win_ready, with no other terms. in_ready may be 1 while in_valid=0.
- accept = in_valid && in_ready && !clear.
- emit = win_valid && win_ready.
- On accept:
  - row r <= row r-1 for r = 1..WIN_ROWS-1; row 0 <= in_row.
  - fill_cnt saturates at WIN_ROWS.
  - since_cnt saturates at WIN_ROWS.
- Without accept, all buffers hold.
- since_cnt_next:
  - emit && accept: 1.
  - emit only: 0.
  - accept only: since_cnt+1 (saturating).
  - neither: since_cnt.
- win_valid_next = (fill_cnt_next == WIN_ROWS) && (since_cnt_next >= eff_stride), registered. eff_stride = 1 if stride==0, else min(stride, WIN_ROWS).
- Latency: a row accepted at edge k is visible in win_data row 0 after edge k. win_valid reflects that row after the same edge.
- First window after clear: emitted after exactly WIN_ROWS accepts, independent of stride.
- Stable-window rule: while win_valid && !win_ready, in_ready=0 and win_data and win_valid are held.
- row_valid[r] = (fill_cnt > r), registered. row_valid[0] rises after the first accept.
- stride is sampled continuously. It is legal to change stride only while fill_cnt==0; any other change is unspecified.
- Reset or clear asserted mid-window drops the pending window; win_valid=0 on the next cycle.
- Pixel arithmetic: none. Data are moved bit-exact.

Decomposition:
- Shared package sys_types: int8_t and a win_row_t (array [WIN_COLS] of signed [DATA_W-1:0]) helper typedef. Add the constant DEFAULT_WIN_ROWS=4.
- One sub-module, window_ctrl. It holds fill_cnt, since_cnt and win_valid, and produces accept, emit and in_ready.
- The top level keeps the row shift register and the output packing.

Test Plan:
- Defaults, stride=1, in_valid held high, win_ready=1, rows R0..R5 = 32'h03020100+i*32'h04040404:
  - win_valid first rises after the 4th accept, with win_data row0=R3 and row3=R0.
  - It then stays high every cycle: after R5, row0=R5 and row3=R2.
  - row_valid goes 0001, 0011, 0111, 1111 over the first four accepts.
- stride=2, 8 rows streamed: windows are emitted after accepts 4, 6 and 8, with row0 = R3, R5, R7 respectively. win_valid is low in the cycles between.
- Backpressure: win_ready=0 when the first window appears.
  - in_ready=0 and win_data is stable for 5 cycles; in_valid with R4 is held pending.
  - On win_ready=1, emit and accept R4 occur in the same cycle.
  - Next cycle win_valid=1 (stride=1) with row0=R4.
- Clear mid-fill: after 2 accepts, assert clear together with in_valid.
  - That row is dropped; row_valid=0000 and win_data=0.
  - The next window needs 4 fresh accepts.
- Reset mid-operation while win_valid=1 and win_ready=0: next cycle win_valid=0, in_ready=1, row_valid=0 and win_data=0.
- Edge/saturation case: stride=0 behaves as stride=1. 20 accepts give fill_cnt=4 and since_cnt≤4 (no wrap), and a window is emitted every accept.

Source files
------------

// File: rtl/sys_types.sv
// Shared types and constants for the conv front-end stream blocks.
package sys_types;

    localparam int DEFAULT_DATA_W   = 8;
    localparam int DEFAULT_WIN_COLS = 4;
    localparam int DEFAULT_WIN_ROWS = 4;

    typedef logic signed [7:0] int8_t;
    typedef logic signed [DEFAULT_DATA_W-1:0] win_row_t [DEFAULT_WIN_COLS];

    // A stride of 0 means 1; strides beyond the window depth clamp to the depth.
    function automatic int unsigned eff_stride(input int unsigned stride,
                                               input int unsigned win_rows);
        if (stride == 32'd0) begin
            return 32'd1;
        end else if (stride > win_rows) begin
            return win_rows;
        end else begin
            return stride;
        end
    endfunction

endpackage

// File: rtl/window_ctrl.sv
// Fill / stride bookkeeping and handshake generation for the row-window buffer.
module window_ctrl
    import sys_types::*;
#(
    parameter int WIN_ROWS = DEFAULT_WIN_ROWS,
    parameter int STRIDE_W = $clog2(WIN_ROWS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_clear,
    input  logic [STRIDE_W-1:0] i_stride,
    input  logic                i_in_valid,
    input  logic                i_win_ready,
    output logic                o_in_ready,
    output logic                o_accept,
    output logic                o_win_valid
);

    localparam int CNT_W = $clog2(WIN_ROWS + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(WIN_ROWS);

    logic [CNT_W-1:0] r_fill_cnt;
    logic [CNT_W-1:0] r_since_cnt;
    logic             r_win_valid;

    logic [CNT_W-1:0] w_fill_next;
    logic [CNT_W-1:0] w_since_next;
    logic             w_win_valid_next;
    logic             w_emit;

    // A held window blocks input, so the presented window cannot change under the consumer.
    assign o_in_ready  = !r_win_valid || i_win_ready;
    assign o_accept    = i_in_valid && o_in_ready && !i_clear;
    assign w_emit      = r_win_valid && i_win_ready;
    assign o_win_valid = r_win_valid;

    // Next-state counters and window-valid decision.
    always_comb begin
        w_fill_next      = r_fill_cnt;
        w_since_next     = r_since_cnt;
        w_win_valid_next = 1'b0;
        if (o_accept && (r_fill_cnt != FULL)) begin
            w_fill_next = r_fill_cnt + CNT_W'(1);
        end else begin
            w_fill_next = r_fill_cnt;
        end
        case ({w_emit, o_accept})
            2'b11:   w_since_next = CNT_W'(1);
            2'b10:   w_since_next = CNT_W'(0);
            2'b01:   w_since_next = (r_since_cnt == FULL) ? FULL : r_since_cnt + CNT_W'(1);
            default: w_since_next = r_since_cnt;
        endcase
        w_win_valid_next = (w_fill_next == FULL) &&
                           (32'(w_since_next) >= eff_stride(32'(i_stride), WIN_ROWS));
    end

    // State registers; reset and frame clear both restart the fill.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_fill_cnt  <= CNT_W'(0);
            r_since_cnt <= CNT_W'(0);
            r_win_valid <= 1'b0;
        end else begin
            r_fill_cnt  <= w_fill_next;
            r_since_cnt <= w_since_next;
            r_win_valid <= w_win_valid_next;
        end
    end

endmodule

// File: rtl/sliding_window_stream.sv
// Row-window buffer: keeps the last WIN_ROWS rows and presents them as one window.
module sliding_window_stream
    import sys_types::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int WIN_COLS = DEFAULT_WIN_COLS,
    parameter int WIN_ROWS = DEFAULT_WIN_ROWS,
    parameter int STRIDE_W = $clog2(WIN_ROWS + 1)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                i_clear,
    input  logic [STRIDE_W-1:0]                 i_stride,
    input  logic                                i_in_valid,
    output logic                                o_in_ready,
    input  logic [WIN_COLS*DATA_W-1:0]          i_in_row,
    output logic                                o_win_valid,
    input  logic                                i_win_ready,
    output logic [WIN_ROWS*WIN_COLS*DATA_W-1:0] o_win_data,
    output logic [WIN_ROWS-1:0]                 o_row_valid
);

    localparam int ROW_W = WIN_COLS * DATA_W;

    logic [ROW_W-1:0]    r_rows [WIN_ROWS];
    logic [WIN_ROWS-1:0] r_row_valid;
    logic                w_accept;

    window_ctrl #(
        .WIN_ROWS (WIN_ROWS),
        .STRIDE_W (STRIDE_W)
    ) u_ctrl (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (i_clear),
        .i_stride    (i_stride),
        .i_in_valid  (i_in_valid),
        .i_win_ready (i_win_ready),
        .o_in_ready  (o_in_ready),
        .o_accept    (w_accept),
        .o_win_valid (o_win_valid)
    );

    // Row shift register; row 0 is always the newest row, row_valid shifts in step.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            for (int r = 0; r < WIN_ROWS; r++) begin
                r_rows[r] <= '0;
            end
            r_row_valid <= '0;
        end else if (w_accept) begin
            r_rows[0]      <= i_in_row;
            r_row_valid[0] <= 1'b1;
            for (int r = 1; r < WIN_ROWS; r++) begin
                r_rows[r]      <= r_rows[r-1];
                r_row_valid[r] <= r_row_valid[r-1];
            end
        end else begin
            for (int r = 0; r < WIN_ROWS; r++) begin
                r_rows[r] <= r_rows[r];
            end
            r_row_valid <= r_row_valid;
        end
    end

    // Pixel layout inside a row already matches the window layout, so rows pack directly.
    for (genvar g = 0; g < WIN_ROWS; g++) begin : g_pack
        assign o_win_data[g*ROW_W +: ROW_W] = r_rows[g];
    end

    assign o_row_valid = r_row_valid;

endmodule

// File: tb/tb_sliding_window_stream.sv
// Directed self-checking bench for sliding_window_stream (default parameters).
module tb_sliding_window_stream;

    logic         clk;
    logic         reset;
    logic         i_clear;
    logic [2:0]   i_stride;
    logic         i_in_valid;
    logic         o_in_ready;
    logic [31:0]  i_in_row;
    logic         o_win_valid;
    logic         i_win_ready;
    logic [127:0] o_win_data;
    logic [3:0]   o_row_valid;

    int checks;
    int failures;

    sliding_window_stream dut (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (i_clear),
        .i_stride    (i_stride),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_row    (i_in_row),
        .o_win_valid (o_win_valid),
        .i_win_ready (i_win_ready),
        .o_win_data  (o_win_data),
        .o_row_valid (o_row_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rv(input int i);
        return 32'h03020100 + 32'(i) * 32'h04040404;
    endfunction

    function automatic logic [31:0] wrow(input logic [127:0] d, input int r);
        return d[r*32 +: 32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; i_clear = 1'b0; i_in_valid = 1'b0; i_win_ready = 1'b1;
        i_stride = 3'd1; i_in_row = 32'd0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (o_win_valid !== 1'b0 || o_row_valid !== 4'b0000 || o_win_data !== 128'd0 || o_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset: win_valid=%b row_valid=%b data=%h in_ready=%b", o_win_valid, o_row_valid, o_win_data, o_in_ready);
        end
    endtask

    task automatic test_stride1();
        logic [3:0] exp_rv;
        do_reset();
        i_in_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            i_in_row = rv(k - 1);
            tick();
            exp_rv = (k >= 4) ? 4'b1111 : 4'((1 << k) - 1);
            checks++;
            if (o_row_valid !== exp_rv || o_win_valid !== (k >= 4)) begin
                failures++;
                $display("FAIL stride1 k=%0d: row_valid=%b exp %b win_valid=%b", k, o_row_valid, exp_rv, o_win_valid);
            end
            if (k >= 4) begin
                checks++;
                if (wrow(o_win_data, 0) !== rv(k - 1) || wrow(o_win_data, 3) !== rv(k - 4)) begin
                    failures++;
                    $display("FAIL stride1_data k=%0d: row0=%h exp %h row3=%h exp %h", k,
                             wrow(o_win_data, 0), rv(k - 1), wrow(o_win_data, 3), rv(k - 4));
                end
            end
        end
        i_in_valid = 1'b0;
    endtask

    task automatic test_stride2();
        logic exp_v;
        do_reset();
        i_stride = 3'd2;
        i_in_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            i_in_row = rv(k - 1);
            tick();
            exp_v = (k == 4) || (k == 6) || (k == 8);
            checks++;
            if (o_win_valid !== exp_v) begin
                failures++;
                $display("FAIL stride2_valid k=%0d: got %b exp %b", k, o_win_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (wrow(o_win_data, 0) !== rv(k - 1)) begin
                    failures++;
                    $display("FAIL stride2_data k=%0d: row0=%h exp %h", k, wrow(o_win_data, 0), rv(k - 1));
                end
            end
        end
        i_in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        i_win_ready = 1'b0;
        i_in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i_in_row = rv(k);
            tick();
        end
        i_in_row = rv(4);
        #1;
        checks++;
        if (o_win_valid !== 1'b1 || o_in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold_start: win_valid=%b in_ready=%b exp 1/0", o_win_valid, o_in_ready);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (o_win_valid !== 1'b1 || o_in_ready !== 1'b0 || wrow(o_win_data, 0) !== rv(3) ||
                wrow(o_win_data, 3) !== rv(0) || o_row_valid !== 4'b1111) begin
                failures++;
                $display("FAIL bp_stable c=%0d: win_valid=%b in_ready=%b row0=%h row3=%h row_valid=%b",
                         c, o_win_valid, o_in_ready, wrow(o_win_data, 0), wrow(o_win_data, 3), o_row_valid);
            end
        end
        i_win_ready = 1'b1;
        #1;
        checks++;
        if (o_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_in_ready_comb: got %b exp 1", o_in_ready);
        end
        tick();
        checks++;
        if (o_win_valid !== 1'b1 || wrow(o_win_data, 0) !== rv(4) || wrow(o_win_data, 1) !== rv(3)) begin
            failures++;
            $display("FAIL bp_release: win_valid=%b row0=%h exp %h row1=%h exp %h",
                     o_win_valid, wrow(o_win_data, 0), rv(4), wrow(o_win_data, 1), rv(3));
        end
        i_in_valid = 1'b0;
        tick();
        checks++;
        if (o_win_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_emit_only: win_valid=%b exp 0", o_win_valid);
        end
    endtask

    task automatic test_clear();
        do_reset();
        i_in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            i_in_row = rv(k);
            tick();
        end
        i_clear = 1'b1;
        i_in_row = rv(2);
        tick();
        i_clear = 1'b0;
        i_in_valid = 1'b0;
        checks++;
        if (o_row_valid !== 4'b0000 || o_win_data !== 128'd0 || o_win_valid !== 1'b0) begin
            failures++;
            $display("FAIL clear_state: row_valid=%b data=%h win_valid=%b", o_row_valid, o_win_data, o_win_valid);
        end
        i_in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            i_in_row = rv(9 + k);
            tick();
            checks++;
            if (o_win_valid !== (k == 4)) begin
                failures++;
                $display("FAIL clear_refill k=%0d: win_valid=%b exp %b", k, o_win_valid, (k == 4));
            end
        end
        checks++;
        if (wrow(o_win_data, 0) !== rv(13) || wrow(o_win_data, 3) !== rv(10)) begin
            failures++;
            $display("FAIL clear_refill_data: row0=%h exp %h row3=%h exp %h",
                     wrow(o_win_data, 0), rv(13), wrow(o_win_data, 3), rv(10));
        end
        i_in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        i_win_ready = 1'b0;
        i_in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i_in_row = rv(k);
            tick();
        end
        i_in_valid = 1'b0;
        checks++;
        if (o_win_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_pre: win_valid=%b exp 1", o_win_valid);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (o_win_valid !== 1'b0 || o_in_ready !== 1'b1 || o_row_valid !== 4'b0000 || o_win_data !== 128'd0) begin
            failures++;
            $display("FAIL reset_mid: win_valid=%b in_ready=%b row_valid=%b data=%h",
                     o_win_valid, o_in_ready, o_row_valid, o_win_data);
        end
    endtask

    task automatic test_stride0_saturation();
        do_reset();
        i_stride = 3'd0;
        i_in_valid = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            i_in_row = rv(k - 1);
            tick();
            if (k >= 4) begin
                checks++;
                if (o_win_valid !== 1'b1 || wrow(o_win_data, 0) !== rv(k - 1) || o_row_valid !== 4'b1111) begin
                    failures++;
                    $display("FAIL stride0 k=%0d: win_valid=%b row0=%h exp %h row_valid=%b",
                             k, o_win_valid, wrow(o_win_data, 0), rv(k - 1), o_row_valid);
                end
            end
        end
        i_in_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1; i_clear = 1'b0; i_stride = 3'd1; i_in_valid = 1'b0;
        i_in_row = 32'd0; i_win_ready = 1'b1;
        test_reset();
        test_stride1();
        test_stride2();
        test_backpressure();
        test_clear();
        test_reset_mid();
        test_stride0_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
